// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and the
// default widths that line up with the divider counters.
package period_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_TIMEOUT = 2**27;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a history flop; emits the synchronized
// level and single-cycle rise/fall pulses.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], sig_in};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in clk cycles, with a
// timeout when no rising edge arrives for TIMEOUT cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic             cnt_at_to;
  logic [CNT_W-1:0] hi_cap;
  logic [CNT_W-1:0] hi_cap_nx;
  logic [CNT_W-1:0] period_nx;
  logic [CNT_W-1:0] high_time_nx;
  logic             valid_nx;
  logic             timeout_nx;
  logic             locked_nx;
  state_t           state;
  state_t           state_nx;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign cnt_at_to = (cnt == TO_VAL);

  // Cycle counter: restarts at 1 on every rise so it equals the rise-to-rise distance.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt_at_to) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state and next-output decode; a rise always takes priority over timeout.
  always_comb begin
    state_nx     = state;
    hi_cap_nx    = hi_cap;
    period_nx    = period;
    high_time_nx = high_time;
    valid_nx     = 1'b0;
    timeout_nx   = timeout;
    locked_nx    = locked;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nx   = ST_MEAS;
          timeout_nx = 1'b0;
        end else if (cnt_at_to) begin
          timeout_nx = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          period_nx    = cnt;
          high_time_nx = hi_cap;
          valid_nx     = 1'b1;
          locked_nx    = 1'b1;
          timeout_nx   = 1'b0;
        end else if (cnt_at_to) begin
          timeout_nx = 1'b1;
          locked_nx  = 1'b0;
          state_nx   = ST_IDLE;
        end else if (fall) begin
          hi_cap_nx = cnt;
        end else begin
          state_nx = ST_MEAS;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      hi_cap    <= hi_cap_nx;
      period    <= period_nx;
      high_time <= high_time_nx;
      valid     <= valid_nx;
      timeout   <= timeout_nx;
      locked    <= locked_nx;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table-driven waveform segments with a
// scoreboard of expected measurements, plus timeout and reset sequences.
module tb_period_meter;

  localparam int CNT_W = 28;
  localparam int SYNC  = 2;
  localparam int TO    = 64;
  localparam int LAT   = TO + SYNC + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             locked;

  typedef struct {
    int h;
    int l;
    int n;
    int ep;
    int eh;
  } seg_t;

  typedef struct {
    int ep;
    int eh;
  } exp_t;

  seg_t  segs[5];
  exp_t  sb[$];
  exp_t  prev;
  exp_t  mon_e;
  bit    have_prev = 1'b0;
  logic  valid_q = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_rise = 0;
  int    ref_cyc = 0;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_time"}, high_time, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  // One full period starting with a rise; that rise completes the previous period.
  task automatic drive_period(input int h, input int l, input int ep, input int eh);
    if (have_prev) sb.push_back(prev);
    sig_in = 1'b1;
    last_rise = cyc;
    step(h);
    sig_in = 1'b0;
    step(l);
    prev.ep = ep;
    prev.eh = eh;
    have_prev = 1'b1;
  endtask

  task automatic wait_timeout(input int from_cyc, input string tag);
    while (timeout !== 1'b1 && (cyc - from_cyc) < 200) step(1);
    chk({tag, "_timeout_latency"}, cyc - from_cyc, LAT);
  endtask

  // Every valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      chk("valid_width", valid_q, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=period %0d high %0d required=no strobe", period, high_time);
      end else begin
        mon_e = sb.pop_front();
        chk("period", period, mon_e.ep);
        chk("high_time", high_time, mon_e.eh);
        chk("locked_on_valid", locked, 1);
        chk("timeout_on_valid", timeout, 0);
      end
    end
    valid_q <= valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    segs = '{'{4, 4, 5, 8, 4}, '{2, 2, 4, 4, 2}, '{1, 1, 4, 2, 1},
             '{3, 7, 3, 10, 3}, '{6, 4, 3, 10, 6}};

    reset = 1'b1;
    sig_in = 1'b0;
    step(2);
    chk_zero("reset");
    reset = 1'b0;
    step(2);

    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        drive_period(segs[s].h, segs[s].l, segs[s].ep, segs[s].eh);
      end
    end

    // Signal stops: timeout after the last rise, last measurement held.
    wait_timeout(last_rise, "stop");
    chk("stop_locked", locked, 0);
    chk("stop_period_hold", period, 10);
    chk("stop_high_hold", high_time, 6);

    // Restart: first rise clears timeout without producing a measurement.
    have_prev = 1'b0;
    sig_in = 1'b1;
    last_rise = cyc;
    step(2);
    chk("restart_timeout_held", timeout, 1);
    step(1);
    chk("restart_timeout_clear", timeout, 0);
    chk("restart_locked", locked, 0);
    step(1);
    sig_in = 1'b0;
    step(4);
    prev.ep = 8;
    prev.eh = 4;
    have_prev = 1'b1;
    drive_period(4, 4, 8, 4);
    drive_period(4, 4, 8, 4);

    // Reset in mid-period discards everything.
    if (have_prev) sb.push_back(prev);
    sig_in = 1'b1;
    step(4);
    sig_in = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    chk_zero("mid_reset");
    reset = 1'b0;
    chk("mid_reset_sb_empty", sb.size(), 0);
    have_prev = 1'b0;
    step(3);
    drive_period(4, 4, 8, 4);
    drive_period(3, 5, 8, 3);
    drive_period(4, 4, 8, 4);

    // Constant-high from reset ends in timeout with no strobe.
    have_prev = 1'b0;
    sig_in = 1'b1;
    reset = 1'b1;
    step(1);
    chk_zero("reset_high");
    reset = 1'b0;
    ref_cyc = cyc;
    wait_timeout(ref_cyc, "const_high");
    chk("const_high_locked", locked, 0);
    chk("const_high_period", period, 0);
    step(10);
    chk("const_high_timeout_stays", timeout, 1);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
